alu_job_scheduler: RTL

- Shares one ALU control unit plus its datapath between NUM_REQ requesters.
- Each requester submits an op (00 add, 01 sub, 10 mul, 11 div) with operands over a valid/ready handshake.
- Arbitration is round-robin. The block pulses BEGIN, steers INBUS from the ALU load strobes, and captures OUTBUS on the push strobes.
- It returns A/Q results through a response handshake, and a timeout watchdog aborts a hung ALU.

---
 rtl/alu_job_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_job_scheduler.sv
// Round-robin scheduler sharing one multi-cycle ALU control unit between NUM_REQ requesters.
// Steers INBUS from the ALU load strobes, captures OUTBUS after pushes, and aborts a hung ALU.
module alu_job_scheduler #(
  parameter int WIDTH          = 8,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_q,
  input  logic [WIDTH*NUM_REQ-1:0] req_m,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_a,
  output logic [WIDTH-1:0]         resp_q,
  output logic                     resp_err,
  output logic                     alu_begin,
  output logic [1:0]               alu_op_code,
  output logic                     alu_reset_input,
  input  logic                     alu_load_a,
  input  logic                     alu_load_q,
  input  logic                     alu_load_m,
  output logic [WIDTH-1:0]         alu_inbus,
  input  logic                     alu_push_a,
  input  logic                     alu_push_q,
  input  logic [WIDTH-1:0]         alu_outbus,
  input  logic                     alu_end,
  output logic                     busy,
  output logic [1:0]               grant_id
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, START, RUN, RESP, ABORT} state_t;
  state_t state, state_nx;

  logic [1:0]         ptr;
  logic [WIDTH-1:0]   op_a, op_q, op_m;
  logic               push_a_d, push_q_d;
  logic [WD_W-1:0]    wdog;

  logic               hi_hit, lo_hit, hit;
  logic [1:0]         hi_sel, lo_sel, sel;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_a, sel_q, sel_m;
  logic [NUM_REQ-1:0] owner_oh;
  logic               own_ready, timeout;

  // Lowest valid index at or above the pointer wins; otherwise the lowest valid index overall.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_sel = '0;
    lo_sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_hit = 1'b1;
        lo_sel = 2'(i);
        if (i >= int'(ptr)) begin
          hi_hit = 1'b1;
          hi_sel = 2'(i);
        end
      end
    end
    hit = lo_hit;
    sel = hi_hit ? hi_sel : lo_sel;
  end

  always_comb begin
    sel_op   = '0;
    sel_a    = '0;
    sel_q    = '0;
    sel_m    = '0;
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (grant_id == 2'(i));
      if (sel == 2'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_q  = req_q[WIDTH*i +: WIDTH];
        sel_m  = req_m[WIDTH*i +: WIDTH];
      end
    end
  end

  assign own_ready = |(resp_ready & owner_oh);
  // The watchdog counts RUN cycles from 0, so this fires on the TIMEOUT_CYCLES-th RUN cycle.
  assign timeout   = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx        = state;
    req_ready       = '0;
    resp_valid      = '0;
    alu_begin       = 1'b0;
    alu_reset_input = 1'b0;
    alu_inbus       = '0;
    case (state)
      IDLE: begin
        for (int i = 0; i < NUM_REQ; i++)
          req_ready[i] = hit && reset && (sel == 2'(i));
        if (hit) state_nx = START;
      end
      START: begin
        alu_begin = 1'b1;
        state_nx  = RUN;
      end
      RUN: begin
        if (alu_load_a)      alu_inbus = op_a;
        else if (alu_load_q) alu_inbus = op_q;
        else if (alu_load_m) alu_inbus = op_m;
        // END beats a coincident timeout.
        if (alu_end)      state_nx = RESP;
        else if (timeout) state_nx = ABORT;
      end
      ABORT: begin
        alu_reset_input = 1'b1;
        state_nx        = RESP;
      end
      RESP: begin
        resp_valid = owner_oh;
        if (own_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      grant_id    <= '0;
      alu_op_code <= '0;
      op_a        <= '0;
      op_q        <= '0;
      op_m        <= '0;
      resp_a      <= '0;
      resp_q      <= '0;
      resp_err    <= 1'b0;
      push_a_d    <= 1'b0;
      push_q_d    <= 1'b0;
      wdog        <= '0;
    end else begin
      // OUTBUS is valid the cycle after its push strobe.
      push_a_d <= alu_push_a;
      push_q_d <= alu_push_q;
      case (state)
        IDLE: if (hit) begin
          grant_id    <= sel;
          alu_op_code <= sel_op;
          op_a        <= sel_a;
          op_q        <= sel_q;
          op_m        <= sel_m;
          resp_a      <= '0;
          resp_q      <= '0;
        end
        START: wdog <= '0;
        RUN: begin
          wdog <= wdog + 1'b1;
          if (push_a_d) resp_a <= alu_outbus;
          if (push_q_d) resp_q <= alu_outbus;
        end
        ABORT: begin
          resp_err <= 1'b1;
          resp_a   <= '0;
          resp_q   <= '0;
        end
        RESP: if (own_ready) begin
          ptr      <= (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
          resp_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
